// File: rtl/crc_tx.sv
// crc_tx: transmit-side Ethernet FCS generator.
// Passes 32-bit frame words through with one cycle of latency and computes
// the reflected CRC-32 over the kept bytes. The 4-byte FCS is packed into the
// free lanes of the last data word. Any FCS bytes that do not fit are sent
// in one extra tail word, so each frame grows by exactly one output word.
module crc_tx #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CRC_W  = 32
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              last_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic              last_o
);

  // The lane packing and the byte loop below assume a 4-byte word.
  generate
    if (DATA_W != 32 || KEEP_W != DATA_W / 8 || CRC_W != 32) begin : g_bad_width
      $error("crc_tx supports only DATA_W=32, KEEP_W=4, CRC_W=32");
    end
  endgenerate

  localparam logic [31:0] POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

  typedef enum logic {
    S_DATA,
    S_TAIL
  } state_t;

  state_t              state_q;
  logic [CRC_W-1:0]    crc_q;
  logic [DATA_W-1:0]   data_q;
  logic [KEEP_W-1:0]   keep_q;
  logic                valid_q;
  logic                last_q;
  logic [DATA_W-1:0]   tail_q;
  logic [KEEP_W-1:0]   tail_keep_q;

  logic [CRC_W-1:0]    crc_d;
  logic [DATA_W-1:0]   data_masked;
  logic [2:0]          kcnt;
  logic [2*DATA_W-1:0] pack_w;
  logic                out_free;
  logic                in_xfer;

  // Fold one byte into a reflected CRC-32, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

  // Unused byte lanes are zeroed so the FCS can be OR-ed into them.
  genvar gi;
  generate
    for (gi = 0; gi < KEEP_W; gi++) begin : g_mask
      assign data_masked[gi*8 +: 8] = keep_i[gi] ? data_i[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // CRC advanced over the kept bytes of the current input word, in lane order.
  always_comb begin
    crc_d = crc_q;
    kcnt  = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (keep_i[i]) begin
        crc_d = crc_byte(crc_d, data_i[i*8 +: 8]);
        kcnt  = kcnt + 3'd1;
      end
    end
  end

  // The FCS is placed right after the k data bytes of a 64-bit window.
  // The low half is the last data word and the high half is the tail word,
  // whose k bytes sit in lanes 0..k-1.
  assign pack_w = ({{DATA_W{1'b0}}, ~crc_d} << {kcnt, 3'b000})
                | {{DATA_W{1'b0}}, data_masked};

  assign out_free = !valid_q || ready_i;
  assign ready_o  = (state_q == S_DATA) && out_free;
  assign in_xfer  = valid_i && ready_o;

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

  // Control FSM with registered output word, tail storage and CRC state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_DATA;
      crc_q       <= CRC_INIT;
      data_q      <= '0;
      keep_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      tail_q      <= '0;
      tail_keep_q <= '0;
    end else begin
      case (state_q)
        S_DATA: begin
          if (in_xfer) begin
            valid_q <= 1'b1;
            keep_q  <= '1;
            last_q  <= 1'b0;
            if (last_i) begin
              data_q      <= pack_w[DATA_W-1:0];
              tail_q      <= pack_w[2*DATA_W-1:DATA_W];
              tail_keep_q <= keep_i;
              crc_q       <= CRC_INIT;
              state_q     <= S_TAIL;
            end else begin
              data_q <= data_masked;
              crc_q  <= crc_d;
            end
          end else if (ready_i) begin
            valid_q <= 1'b0;
          end
        end
        S_TAIL: begin
          if (out_free) begin
            valid_q <= 1'b1;
            data_q  <= tail_q;
            keep_q  <= tail_keep_q;
            last_q  <= 1'b1;
            state_q <= S_DATA;
          end
        end
        default: state_q <= S_DATA;
      endcase
    end
  end

  // Input byte enables must be contiguous from lane 0, non-empty, and full
  // except on the last word of a frame.
  logic keep_contig;
  logic keep_legal;
  assign keep_contig = (keep_i == 4'b0001) || (keep_i == 4'b0011) ||
                       (keep_i == 4'b0111) || (keep_i == 4'b1111);
  assign keep_legal  = keep_contig && (last_i || keep_i == 4'b1111);

  a_keep_legal: assert property (@(posedge clk) disable iff (!nreset)
                                 valid_i |-> keep_legal)
    else $error("crc_tx: illegal keep_i=%b last_i=%b", keep_i, last_i);

endmodule

// File: tb/tb_crc_tx.sv
// tb_crc_tx: scoreboard bench for crc_tx using directed frames with
// hand-computed FCS words.
module tb_crc_tx;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_i = '0;
  logic [3:0]  keep_i = 4'b1111;
  logic        last_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] data_o;
  logic [3:0]  keep_o;
  logic        last_o;

  crc_tx dut (
    .clk     (clk),
    .nreset  (nreset),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .keep_i  (keep_i),
    .last_i  (last_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .keep_o  (keep_o),
    .last_o  (last_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    ready_mode = 1;    // 0 low, 1 high, 2 random
  bit    cnt_en = 1'b0;
  int    ready_low_cnt = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endfunction

  function automatic void push(logic [31:0] d, logic [3:0] k, logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    exp_q.push_back(b);
  endfunction

  // Downstream ready driver, updated just after each active edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ready_i = 1'b0;
      2:       ready_i = 1'($urandom_range(0, 1));
      default: ready_i = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on each output transfer and checks that a
  // stalled output holds still while ready_o stays low.
  beat_t held;
  bit    prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (!nreset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(valid_o), 32'd1);
        chk("stall_data", data_o, held.d);
        chk("stall_keep", 32'(keep_o), 32'(held.k));
        chk("stall_last", 32'(last_o), 32'(held.l));
      end
      if (valid_o && !ready_i) begin
        chk("ready_o_bp", 32'(ready_o), 32'd0);
        held.d = data_o; held.k = keep_o; held.l = last_o;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (valid_o && ready_i) begin
        $display("out: data=%h keep=%b last=%b", data_o, keep_o, last_o);
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(valid_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", data_o, e.d);
          chk("out_keep", 32'(keep_o), 32'(e.k));
          chk("out_last", 32'(last_o), 32'(e.l));
        end
      end
      if (cnt_en && !ready_o) ready_low_cnt++;
    end
  end

  task automatic send(logic [31:0] d, logic [3:0] k, logic l);
    int n;
    valid_i = 1'b1; data_i = d; keep_i = k; last_i = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (ready_o) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  task automatic idle();
    valid_i = 1'b0; keep_i = 4'b1111; last_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic frame_123456789();
    push(32'h34333231, 4'b1111, 1'b0);
    push(32'h38373635, 4'b1111, 1'b0);
    push(32'hF4392639, 4'b1111, 1'b0);
    push(32'h000000CB, 4'b0001, 1'b1);
    send(32'h34333231, 4'b1111, 1'b0);
    send(32'h38373635, 4'b1111, 1'b0);
    send(32'h00000039, 4'b0001, 1'b1);
  endtask

  task automatic frame_a();
    push(32'hB7BE4361, 4'b1111, 1'b0);
    push(32'h000000E8, 4'b0001, 1'b1);
    send(32'h00000061, 4'b0001, 1'b1);
  endtask

  initial begin
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    #1;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_data_o", data_o, 32'd0);
    chk("rst_keep_o", 32'(keep_o), 32'd0);
    chk("rst_last_o", 32'(last_o), 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk); #1;

    // "123456789"
    frame_123456789(); idle(); wait_drain();

    // four zero bytes, aligned
    push(32'h00000000, 4'b1111, 1'b0);
    push(32'h2144DF1C, 4'b1111, 1'b1);
    send(32'h00000000, 4'b1111, 1'b1); idle(); wait_drain();

    // single byte 'a'
    frame_a(); idle(); wait_drain();

    // backpressure
    ready_mode = 2;
    frame_123456789(); idle(); wait_drain();
    ready_mode = 1;
    repeat (2) @(posedge clk); #1;

    // back-to-back frames, valid_i held high
    ready_low_cnt = 0;
    cnt_en = 1'b1;
    frame_123456789();
    frame_a();
    idle();
    wait_drain();
    cnt_en = 1'b0;
    chk("b2b_ready_low_cycles", 32'(ready_low_cnt), 32'd2);

    // reset mid-frame
    ready_mode = 0;
    repeat (2) @(posedge clk); #1;
    send(32'h34333231, 4'b1111, 1'b0);
    idle();
    #2;
    chk("pre_rst_valid_o", 32'(valid_o), 32'd1);
    nreset = 1'b0;
    #1;
    chk("mid_rst_valid_o", 32'(valid_o), 32'd0);
    chk("mid_rst_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    nreset = 1'b1;
    ready_mode = 1;
    repeat (2) @(posedge clk); #1;
    frame_a(); idle(); wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_tx.md
Name: crc_tx

Overview:
- Transmit-side Ethernet FCS generator. It sits between the TX MAC framer and the PCS.
- It accepts a frame as a stream of 32-bit words, passes the data through, and computes IEEE 802.3 CRC-32 on the fly.
- It appends the 4-byte FCS immediately after the last data byte, packing it into the last data word where there is room.
- It is the counterpart of the receive-side CRC checker.

Parameters:
- DATA_W, 32, data path width in bits; only 32 is supported, and the block must error at elaboration otherwise.
- KEEP_W, DATA_W/8, byte-enable width.
- CRC_W, 32, FCS width.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- valid_i  in  1  input word valid.
- ready_o  out  1  block can accept an input word.
- data_i  in  32  frame bytes; byte 0 (first on the wire) is in [7:0].
- keep_i  in  4  byte enables; contiguous from bit 0. Must be 4'b1111 unless last_i is high.
- last_i  in  1  last data word of the frame.
- valid_o  out  1  output word valid.
- ready_i  in  1  downstream accepts the output word.
- data_o  out  32  frame bytes plus FCS; unused bytes are driven to 0.
- keep_o  out  4  output byte enables.
- last_o  out  1  final word of the frame, including FCS.

Behaviour:
- Handshakes:
  - An input transfer occurs when valid_i and ready_o are both high; an output transfer occurs when valid_o and ready_i are both high.
  - Once valid_o is high, data_o, keep_o and last_o hold stable until the output transfer.
- CRC arithmetic:
  - Reflected CRC-32, polynomial 0x04C11DB7 (reflected 0xEDB88320), initial value 0xFFFFFFFF.
  - Bytes are processed LSB-first, in byte order 0..3; only bytes with keep_i set are included.
  - FCS = ~crc. It is transmitted with FCS[7:0] first, then [15:8], [23:16], [31:24].
- Reset:
  - valid_o=0, data_o=0, keep_o=0, last_o=0, ready_o=1 once nreset deasserts.
  - crc register = 0xFFFFFFFF; state = DATA.
- States:
  - DATA: pass input words through. ready_o = !valid_o || ready_i.
    - On an input transfer, the output register loads the word with 1-cycle latency.
    - The CRC updates over the kept bytes.
    - Non-last words: output keep = 4'b1111, last_o = 0.
    - On a transfer with last_i high and k = popcount(keep_i), k in 1..4:
      - The output word carries the k data bytes, then FCS bytes 0..(3-k) in byte lanes k..3. keep_o = 4'b1111, last_o = 0.
      - Remaining FCS bytes (4-k+... i.e. FCS bytes (4-k)..3, k of them) are stored in a tail register; go to TAIL.
      - The crc register reinitialises to 0xFFFFFFFF in the same cycle.
  - TAIL: ready_o = 0.
    - When the output register is free or transferring, load the stored FCS bytes into lanes 0..k-1, with keep_o = k ones from bit 0 and last_o = 1. Go to DATA.
- Output length: every frame produces exactly one more output word than input words.
- Throughput:
  - Back-to-back frames are supported.
  - With ready_i held high, there is one idle input cycle per frame (during TAIL).
  - There are no bubbles within a frame.
- Backpressure:
  - If ready_i stays low, the output holds. ready_o drops, and input words are neither lost nor duplicated.
  - The CRC advances only on input transfers.
- Illegal inputs:
  - keep_i == 0 with valid_i, non-contiguous keep_i, and partial keep_i without last_i are illegal. Behaviour is undefined; an assertion must flag them in simulation.
- Reset mid-frame: nreset asserted at any time returns all state to reset values immediately. The partial frame is dropped, with no FCS emitted.
- Minimum frame: a single 1-byte word is legal.

Test Plan:
- Frame "123456789" (CRC 0xCBF43926):
  - Input: 0x34333231/1111, 0x38373635/1111, 0x00000039/0001/last.
  - Required output: 0x34333231/1111, 0x38373635/1111, 0xF4392639/1111/last=0, 0x000000CB/0001/last=1.
- Aligned frame of four zero bytes (CRC 0x2144DF1C):
  - Input: 0x00000000/1111/last.
  - Required output: 0x00000000/1111, then 0x2144DF1C/1111/last=1.
- One-byte frame 'a' (CRC 0xE8B7BE43):
  - Input: 0x00000061/0001/last.
  - Required output: 0xB7BE4361/1111, then 0x000000E8/0001/last=1.
- Backpressure:
  - Repeat the first scenario with ready_i randomly low about 50% of the time.
  - Required: an identical output word sequence, outputs stable while stalled, and ready_o low whenever valid_o is high and ready_i is low.
- Back-to-back frames:
  - Send the first frame then the third frame with valid_i held high.
  - Required: both FCS values correct (CRC reinitialised between frames); ready_o low for exactly one cycle per frame with ready_i high.
- Reset mid-frame:
  - Assert nreset after 1 word of the first frame.
  - Required: valid_o=0 immediately. A subsequent frame of 'a' gives the third scenario's output exactly.
